ip_hdr_gen: RTL and testbench
=============================

# ip_hdr_gen

Builds a 20-byte IPv4 header for each outgoing UDP/IP frame on the GbE transmit path. It feeds the ten header words to the external 16-bit ones'-complement checksum calculator through its start/valid/end interface, then captures the calculator's result. It emits the completed header, with the checksum inserted, as a 16-bit word stream with valid/ready backpressure toward the frame assembler.

## Interface
Parameters
- U_DLY, 1, simulation delay on register assignments.

Ports
- clk  in  1  system clock.
- rst  in  1  reset; synchronous, active-high.
- hdr_req  in  1  one-cycle request; accepted only in IDLE.
- total_len  in  16  IPv4 total length, sampled on accept.
- ttl  in  8  TTL, sampled on accept.
- protocol  in  8  protocol field, sampled on accept.
- src_ip  in  32  source address, sampled on accept.
- dst_ip  in  32  destination address, sampled on accept.
- hdr_busy  out  1  high whenever the FSM is not in IDLE.
- chk_start  out  1  clears the checksum accumulator.
- chk_init  out  32  constant 32'h0.
- chk_val  out  1  checksum data valid.
- chk_data  out  16  checksum data word.
- chk_end  out  1  checksum result request.
- chk_result  in  16  checksum result; valid combinationally while chk_end is high.
- hdr_val  out  1  header word valid.
- hdr_data  out  16  header word.
- hdr_sop  out  1  marks word 0.
- hdr_eop  out  1  marks word 9.
- hdr_rdy  in  1  downstream ready.

## Operation
- Header words 0–9:
  - W0 = 16'h4500
  - W1 = total_len
  - W2 = ident
  - W3 = 16'h4000 (DF set, fragment offset 0)
  - W4 = {ttl, protocol}
  - W5 = checksum
  - W6/W7 = src_ip[31:16]/[15:0]
  - W8/W9 = dst_ip[31:16]/[15:0]
- FSM states: IDLE → START → CALC → FOLD → SEND → IDLE.
  - IDLE: when hdr_req=1, latch all fields and go to START.
  - START: chk_start=1 for one cycle; go to CALC.
  - CALC: 10 cycles with chk_val=1 and chk_data=W0..W9. W5 is sent as 16'h0000. A 4-bit word counter runs 0..9 and then goes to FOLD.
  - FOLD: chk_end=1, chk_val=0. Latch chk_result into the checksum register. Go to SEND.
  - SEND: present Wn on hdr_data with hdr_val=1. The counter advances only when hdr_val && hdr_rdy. Word 9 accepted → IDLE.
- hdr_req outside IDLE is ignored; it is not queued.
- Ident counter (16 bit) increments by 1 when word 9 is accepted. It wraps 16'hFFFF → 16'h0000.
- In SEND, hdr_data, hdr_sop and hdr_eop hold stable while hdr_rdy=0.
- All outputs are registered.

## Timing
- Reset values: every output is 0 (chk_init is always 0). The ident counter resets to 0 and the FSM to IDLE.
- hdr_req high at cycle N (in IDLE):
  - chk_start at N+1.
  - chk_val at N+2..N+11.
  - chk_end at N+12.
  - First hdr_val (W0, hdr_sop=1) at N+13.
- With hdr_rdy held high, hdr_eop is at N+22, hdr_busy falls at N+23, and a new hdr_req is accepted at N+23.
- Total latency from request to first word is 13 cycles. Each stall cycle on hdr_rdy adds 1 cycle.
- hdr_rdy is ignored outside SEND.
- rst asserted in any state:
  - Next cycle the FSM is in IDLE with all outputs 0.
  - The in-flight header is discarded with no partial eop.
  - The ident counter returns to 0.
- If hdr_req and rst are high in the same cycle, rst wins and the request is dropped.

## Configuration
- IP_HDR_IDENT_EN defined: W2 carries the incrementing ident counter as described above.
- IP_HDR_IDENT_EN undefined:
  - W2 = 16'h0000 for every header.
  - The ident counter is not instantiated.
  - All other behaviour is unchanged.

## Test plan
- Reference header, first request after reset (macro defined):
  - Inputs: total_len=16'h0073, ttl=8'h40, protocol=8'h11, src=C0A8_0001, dst=C0A8_00C7.
  - Expected: chk_data sequence 4500,0073,0000,4000,4011,0000,C0A8,0001,C0A8,00C7, then hdr_data W5=16'hB861.
  - hdr_sop only on W0, hdr_eop only on W9, first hdr_val at N+13.
- Repeat the same inputs → W2=16'h0001, W5=16'hB860. With IP_HDR_IDENT_EN undefined, both headers carry W2=16'h0000 and W5=16'hB861.
- hdr_rdy low for 3 cycles while W4 is presented:
  - W4 stays on hdr_data with hdr_val=1 for 4 cycles.
  - No word is skipped or duplicated.
  - eop arrives 3 cycles late.
- hdr_req pulsed at N+5 and at N+15 during a header → both ignored. Exactly one header is emitted and the ident counter advances by 1.
- rst asserted at N+8 (mid-CALC) and again mid-SEND:
  - All outputs are 0 the next cycle and hdr_busy=0.
  - A following request yields the full reference header with W2=16'h0000.
- Force the ident counter to 16'hFFFF (IP_HDR_IDENT_EN defined), then send → W2=16'hFFFF on this header, and the next header carries W2=16'h0000.

Source files
------------

// File: rtl/ip_hdr_gen.sv
// IPv4 header builder: feeds the ten header words to an external ones'-complement checksum
// unit, then streams the finished header as 16-bit words. Optional macro: IP_HDR_IDENT_EN.
module ip_hdr_gen #(
   parameter int U_DLY = 1
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        hdr_req,
   input  logic [15:0] total_len,
   input  logic [7:0]  ttl,
   input  logic [7:0]  protocol,
   input  logic [31:0] src_ip,
   input  logic [31:0] dst_ip,
   output logic        hdr_busy,
   output logic        chk_start,
   output logic [31:0] chk_init,
   output logic        chk_val,
   output logic [15:0] chk_data,
   output logic        chk_end,
   input  logic [15:0] chk_result,
   output logic        hdr_val,
   output logic [15:0] hdr_data,
   output logic        hdr_sop,
   output logic        hdr_eop,
   input  logic        hdr_rdy
);

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_START = 3'd1,
      S_CALC  = 3'd2,
      S_FOLD  = 3'd3,
      S_SEND  = 3'd4
   } state_t;

   state_t      state_r;
   logic [3:0]  cnt_r;
   logic [15:0] total_len_r;
   logic [7:0]  ttl_r;
   logic [7:0]  protocol_r;
   logic [31:0] src_ip_r;
   logic [31:0] dst_ip_r;
   logic [15:0] csum_r;
   logic [15:0] ident_s;
   logic        unused_dly_s;

   assign chk_init     = 32'h0000_0000;
   assign unused_dly_s = (U_DLY != 32'sd0);

   // Header word n; the checksum slot takes csum (zero while the checksum is being computed)
   function automatic logic [15:0] hdr_word(input logic [3:0] idx, input logic [15:0] csum);
      logic [15:0] w;
      case (idx)
         4'd0:    w = 16'h4500;
         4'd1:    w = total_len_r;
         4'd2:    w = ident_s;
         4'd3:    w = 16'h4000;
         4'd4:    w = {ttl_r, protocol_r};
         4'd5:    w = csum;
         4'd6:    w = src_ip_r[31:16];
         4'd7:    w = src_ip_r[15:0];
         4'd8:    w = dst_ip_r[31:16];
         4'd9:    w = dst_ip_r[15:0];
         default: w = 16'h0000;
      endcase
      return w;
   endfunction

`ifdef IP_HDR_IDENT_EN
   logic [15:0] ident_r;

   // Identification advances once per fully delivered header, wrapping naturally
   always_ff @(posedge clk) begin
      if (rst) begin
         ident_r <= 16'h0000;
      end else if (state_r == S_SEND && hdr_val && hdr_rdy && cnt_r == 4'd9) begin
         ident_r <= ident_r + 16'h0001;
      end
   end

   assign ident_s = ident_r;
`else
   assign ident_s = 16'h0000;
`endif

   // Header sequencer: outputs are registered one state ahead of the cycle they appear in
   always_ff @(posedge clk) begin
      if (rst) begin
         state_r     <= S_IDLE;
         cnt_r       <= 4'd0;
         total_len_r <= 16'h0000;
         ttl_r       <= 8'h00;
         protocol_r  <= 8'h00;
         src_ip_r    <= 32'h0000_0000;
         dst_ip_r    <= 32'h0000_0000;
         csum_r      <= 16'h0000;
         hdr_busy    <= 1'b0;
         chk_start   <= 1'b0;
         chk_val     <= 1'b0;
         chk_data    <= 16'h0000;
         chk_end     <= 1'b0;
         hdr_val     <= 1'b0;
         hdr_data    <= 16'h0000;
         hdr_sop     <= 1'b0;
         hdr_eop     <= 1'b0;
      end else begin
         case (state_r)
            S_IDLE: begin
               if (hdr_req) begin
                  total_len_r <= total_len;
                  ttl_r       <= ttl;
                  protocol_r  <= protocol;
                  src_ip_r    <= src_ip;
                  dst_ip_r    <= dst_ip;
                  hdr_busy    <= 1'b1;
                  chk_start   <= 1'b1;
                  state_r     <= S_START;
               end
            end
            S_START: begin
               chk_start <= 1'b0;
               chk_val   <= 1'b1;
               chk_data  <= hdr_word(4'd0, 16'h0000);
               cnt_r     <= 4'd0;
               state_r   <= S_CALC;
            end
            S_CALC: begin
               if (cnt_r == 4'd9) begin
                  chk_val  <= 1'b0;
                  chk_data <= 16'h0000;
                  chk_end  <= 1'b1;
                  state_r  <= S_FOLD;
               end else begin
                  cnt_r    <= cnt_r + 4'd1;
                  chk_data <= hdr_word(cnt_r + 4'd1, 16'h0000);
               end
            end
            S_FOLD: begin
               chk_end  <= 1'b0;
               csum_r   <= chk_result;
               cnt_r    <= 4'd0;
               hdr_val  <= 1'b1;
               hdr_sop  <= 1'b1;
               hdr_eop  <= 1'b0;
               hdr_data <= hdr_word(4'd0, chk_result);
               state_r  <= S_SEND;
            end
            S_SEND: begin
               if (hdr_val && hdr_rdy) begin
                  if (cnt_r == 4'd9) begin
                     cnt_r    <= 4'd0;
                     hdr_val  <= 1'b0;
                     hdr_data <= 16'h0000;
                     hdr_sop  <= 1'b0;
                     hdr_eop  <= 1'b0;
                     hdr_busy <= 1'b0;
                     state_r  <= S_IDLE;
                  end else begin
                     cnt_r    <= cnt_r + 4'd1;
                     hdr_data <= hdr_word(cnt_r + 4'd1, csum_r);
                     hdr_sop  <= 1'b0;
                     hdr_eop  <= (cnt_r == 4'd8);
                  end
               end
            end
            default: begin
               state_r   <= S_IDLE;
               cnt_r     <= 4'd0;
               hdr_busy  <= 1'b0;
               chk_start <= 1'b0;
               chk_val   <= 1'b0;
               chk_data  <= 16'h0000;
               chk_end   <= 1'b0;
               hdr_val   <= 1'b0;
               hdr_data  <= 16'h0000;
               hdr_sop   <= 1'b0;
               hdr_eop   <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_ip_hdr_gen.sv
// Directed table-driven bench for ip_hdr_gen, including a behavioural model of the checksum unit.
module tb_ip_hdr_gen;

`ifdef IP_HDR_IDENT_EN
   localparam bit IDENT_EN = 1'b1;
`else
   localparam bit IDENT_EN = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        rst;
   logic        hdr_req;
   logic [15:0] total_len;
   logic [7:0]  ttl;
   logic [7:0]  protocol;
   logic [31:0] src_ip;
   logic [31:0] dst_ip;
   logic        hdr_busy;
   logic        chk_start;
   logic [31:0] chk_init;
   logic        chk_val;
   logic [15:0] chk_data;
   logic        chk_end;
   logic [15:0] chk_result;
   logic        hdr_val;
   logic [15:0] hdr_data;
   logic        hdr_sop;
   logic        hdr_eop;
   logic        hdr_rdy;

   int total = 0;
   int bad   = 0;

   ip_hdr_gen #(.U_DLY(1)) dut (
      .clk(clk), .rst(rst), .hdr_req(hdr_req), .total_len(total_len), .ttl(ttl),
      .protocol(protocol), .src_ip(src_ip), .dst_ip(dst_ip), .hdr_busy(hdr_busy),
      .chk_start(chk_start), .chk_init(chk_init), .chk_val(chk_val), .chk_data(chk_data),
      .chk_end(chk_end), .chk_result(chk_result), .hdr_val(hdr_val), .hdr_data(hdr_data),
      .hdr_sop(hdr_sop), .hdr_eop(hdr_eop), .hdr_rdy(hdr_rdy)
   );

   always #5 clk = ~clk;

   // External checksum calculator: clear on start, accumulate on valid, folded complement on end
   logic [31:0] acc = 32'h0000_0000;
   logic [16:0] f1;
   logic [15:0] f2;
   always @(posedge clk) begin
      if (chk_start)    acc <= 32'h0000_0000;
      else if (chk_val) acc <= acc + {16'h0000, chk_data};
   end
   always_comb begin
      f1 = {1'b0, acc[15:0]} + {1'b0, acc[31:16]};
      f2 = f1[15:0] + {15'h0000, f1[16]};
      chk_result = chk_end ? ~f2 : 16'h0000;
   end

   typedef struct {
      logic [15:0] total_len;
      logic [7:0]  ttl;
      logic [7:0]  protocol;
      logic [31:0] src;
      logic [31:0] dst;
      int          stall_word;
      int          stall_n;
      bit          extra_req;
      logic [15:0] w2_en;
      logic [15:0] w5_en;
      logic [15:0] w5_dis;
   } vec_t;

   vec_t vecs[5];
   vec_t ref_v;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic run_hdr(input vec_t v, input logic [15:0] w2, input logic [15:0] w5);
      logic [15:0] exp_w [10];
      int w;
      int k;
      int stall_left;
      int w4_cycles;
      exp_w = '{16'h4500, v.total_len, w2, 16'h4000, {v.ttl, v.protocol}, w5,
                v.src[31:16], v.src[15:0], v.dst[31:16], v.dst[15:0]};
      total_len = v.total_len;
      ttl       = v.ttl;
      protocol  = v.protocol;
      src_ip    = v.src;
      dst_ip    = v.dst;
      hdr_rdy   = 1'b1;
      hdr_req   = 1'b1;
      for (k = 1; k <= 12; k++) begin
         @(negedge clk);
         hdr_req = v.extra_req && (k == 5);
         if (k == 1) begin
            check("chk_start", chk_start, 1);
            check("busy_start", hdr_busy, 1);
         end else if (k <= 11) begin
            check("chk_val", chk_val, 1);
            check("chk_data", chk_data, (k == 7) ? 16'h0000 : exp_w[k-2]);
         end else begin
            check("chk_end", {chk_end, chk_val}, 2'b10);
         end
      end
      w = 0;
      stall_left = v.stall_n;
      w4_cycles = 0;
      while (w < 10 && k < 40) begin
         @(negedge clk);
         hdr_req = v.extra_req && (k == 15);
         if (hdr_val !== 1'b1) begin
            check("hdr_val", hdr_val, 1);
            break;
         end
         check("hdr_data", hdr_data, exp_w[w]);
         check("sop_eop", {hdr_sop, hdr_eop}, {w == 0, w == 9});
         if (w == 4) w4_cycles++;
         if (w == v.stall_word && stall_left > 0) begin
            hdr_rdy = 1'b0;
            stall_left--;
         end else begin
            hdr_rdy = 1'b1;
            if (w == 9) check("eop_cycle", k, 22 + v.stall_n);
            w++;
         end
         k++;
      end
      if (w < 10) check("words_done", w, 10);
      check("w4_cycles", w4_cycles, (v.stall_word == 4) ? 1 + v.stall_n : 1);
      @(negedge clk);
      hdr_req = 1'b0;
      hdr_rdy = 1'b1;
      check("post_idle", {hdr_busy, hdr_val, hdr_eop}, 3'b000);
      @(negedge clk);
      @(negedge clk);
      check("no_requeue", {chk_start, hdr_busy}, 2'b00);
   endtask

   task automatic abort_hdr(input int at_k);
      total_len = ref_v.total_len;
      ttl       = ref_v.ttl;
      protocol  = ref_v.protocol;
      src_ip    = ref_v.src;
      dst_ip    = ref_v.dst;
      hdr_rdy   = 1'b1;
      hdr_req   = 1'b1;
      for (int k = 1; k <= at_k; k++) begin
         @(negedge clk);
         hdr_req = 1'b0;
      end
      check("busy_before_rst", hdr_busy, 1);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      check("rst_outputs", {hdr_busy, chk_start, chk_val, chk_data, chk_end,
                            hdr_val, hdr_data, hdr_sop, hdr_eop}, 0);
      for (int k = 0; k < 3; k++) @(negedge clk);
      check("rst_no_eop", {hdr_val, hdr_eop, hdr_busy}, 3'b000);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      ref_v = '{16'h0073, 8'h40, 8'h11, 32'hC0A8_0001, 32'hC0A8_00C7, 99, 0, 1'b0,
                16'h0000, 16'hB861, 16'hB861};
      vecs[0] = ref_v;
      vecs[1] = ref_v;
      vecs[1].w2_en = 16'h0001;
      vecs[1].w5_en = 16'hB860;
      vecs[2] = '{16'h0020, 8'hFF, 8'h06, 32'h0A00_0001, 32'h0A00_0002, 4, 3, 1'b0,
                  16'h0002, 16'h67D3, 16'h67D5};
      vecs[3] = '{16'hFFFF, 8'h00, 8'h00, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 99, 0, 1'b1,
                  16'h0003, 16'h7AFC, 16'h7AFF};
      vecs[4] = ref_v;
      vecs[4].w2_en = 16'h0004;
      vecs[4].w5_en = 16'hB85D;

      rst = 1'b1; hdr_req = 1'b0; hdr_rdy = 1'b0;
      total_len = 16'h0000; ttl = 8'h00; protocol = 8'h00;
      src_ip = 32'h0000_0000; dst_ip = 32'h0000_0000;
      @(negedge clk);
      @(negedge clk);
      check("reset_outputs", {hdr_busy, chk_start, chk_val, chk_data, chk_end,
                              hdr_val, hdr_data, hdr_sop, hdr_eop}, 0);
      check("chk_init", chk_init, 32'h0000_0000);
      rst = 1'b0;
      @(negedge clk);

      for (int i = 0; i < 5; i++) begin
         run_hdr(vecs[i], IDENT_EN ? vecs[i].w2_en : 16'h0000,
                 IDENT_EN ? vecs[i].w5_en : vecs[i].w5_dis);
      end

      // Reset mid-CALC, then reset together with a request
      abort_hdr(8);
      total_len = ref_v.total_len;
      hdr_req = 1'b1;
      rst = 1'b1;
      @(negedge clk);
      hdr_req = 1'b0;
      rst = 1'b0;
      check("rst_wins", {hdr_busy, chk_start}, 2'b00);
      @(negedge clk);
      run_hdr(ref_v, 16'h0000, 16'hB861);

      // Reset mid-SEND clears ident again
      abort_hdr(16);
      run_hdr(ref_v, 16'h0000, 16'hB861);

`ifdef IP_HDR_IDENT_EN
      abort_hdr(3);
      force dut.ident_r = 16'hFFFF;
      @(negedge clk);
      release dut.ident_r;
      run_hdr(ref_v, 16'hFFFF, 16'hB861);
      run_hdr(ref_v, 16'h0000, 16'hB861);
`else
      run_hdr(ref_v, 16'h0000, 16'hB861);
      run_hdr(ref_v, 16'h0000, 16'hB861);
`endif

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
